// File: rtl/icache_fetch_if.sv
// Fetch-side bundle of the instruction cache: PC request/response plus the
// memory controller's instruction read port.
interface icache_fetch_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache. Hits are combinational;
// a miss fetches a single word over iREN/iwait and serves it from the line.
module icache_fetch #(
    parameter int NSETS = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    icache_fetch_if.slave bus
);
    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {IDLE, MISS} state_t;

    state_t            state_q, state_d;
    logic              iren_q, iren_d;
    logic [31:0]       iaddr_q, iaddr_d;
    logic [NSETS-1:0]  valid_q, valid_d;
    logic [TAGW-1:0]   tag_q  [NSETS];
    logic [31:0]       data_q [NSETS];

    logic [IDXW-1:0]   req_idx, fill_idx;
    logic [TAGW-1:0]   req_tag, fill_tag;
    logic              hit, fill, ihit_w;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^bus.imemaddr[1:0];

    always_comb begin
        req_idx  = bus.imemaddr[IDXW+1:2];
        req_tag  = bus.imemaddr[31:IDXW+2];
        fill_idx = iaddr_q[IDXW+1:2];
        fill_tag = iaddr_q[31:IDXW+2];
        hit      = bus.imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

        state_d  = state_q;
        iren_d   = iren_q;
        iaddr_d  = iaddr_q;
        valid_d  = valid_q;
        fill     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.imemREN && !hit) begin
                    state_d = MISS;
                    iren_d  = 1'b1;
                    iaddr_d = {bus.imemaddr[31:2], 2'b00};
                end
            end
            MISS: begin
                // iaddr_q doubles as the pending miss address; a PC redirect
                // cannot disturb it until the fill lands.
                if (!bus.iwait) begin
                    fill              = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    state_d           = IDLE;
                    iren_d            = 1'b0;
                    iaddr_d           = '0;
                end
            end
            default: begin
                state_d = IDLE;
                iren_d  = 1'b0;
                iaddr_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            iren_q  <= 1'b0;
            iaddr_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            iren_q  <= iren_d;
            iaddr_q <= iaddr_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data need no reset: valid gates every use of them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.iload;
        end
    end

    assign ihit_w       = (state_q == IDLE) & hit;
    assign bus.ihit     = ihit_w;
    assign bus.imemload = ihit_w ? data_q[req_idx] : '0;
    assign bus.iREN     = iren_q;
    assign bus.iaddr    = iaddr_q;
endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: a memory responder with adjustable latency,
// a cache-level reference model checked every cycle, and literal spot checks.
module tb_icache_fetch;
    localparam int NSETS = 16;

    logic CLK = 1'b0;
    logic nRST;
    icache_fetch_if bus();

    icache_fetch #(.NSETS(NSETS)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 3;
    int mem_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h8C01_0004;
            32'h0000_0004: return 32'h1111_1111;
            32'h0000_0044: return 32'h2222_2222;
            default:       return 32'hC0DE_0000 ^ (a * 32'd3);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory: holds iwait high for `lat` cycles of each request, then returns data.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (bus.iREN) begin
                if (mem_cnt < lat) begin
                    bus.iwait = 1'b1;
                    bus.iload = 32'hDEAD_BEEF;
                    mem_cnt++;
                end else begin
                    bus.iwait = 1'b0;
                    bus.iload = mem_word(bus.iaddr);
                end
            end else begin
                mem_cnt   = 0;
                bus.iwait = 1'b1;
                bus.iload = 32'hDEAD_BEEF;
            end
        end
    end

    // Reference model: lines keyed by index hold the full word address cached there.
    logic [31:0] m_addr [NSETS];
    logic [31:0] m_data [NSETS];
    bit          m_vld  [NSETS];
    bit          m_busy;
    logic [31:0] m_miss;

    initial begin
        int          idx;
        logic [31:0] wa;
        bit          h;
        m_busy = 1'b0;
        for (int i = 0; i < NSETS; i++) m_vld[i] = 1'b0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                check("mdl_rst_ihit", {31'd0, bus.ihit}, 32'd0);
                check("mdl_rst_load", bus.imemload, 32'd0);
                check("mdl_rst_iren", {31'd0, bus.iREN}, 32'd0);
                check("mdl_rst_iaddr", bus.iaddr, 32'd0);
                for (int i = 0; i < NSETS; i++) m_vld[i] = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy) begin
                check("mdl_miss_ihit", {31'd0, bus.ihit}, 32'd0);
                check("mdl_miss_load", bus.imemload, 32'd0);
                check("mdl_miss_iren", {31'd0, bus.iREN}, 32'd1);
                check("mdl_miss_iaddr", bus.iaddr, m_miss);
                if (!bus.iwait) begin
                    idx         = int'((m_miss >> 2) % NSETS);
                    m_vld[idx]  = 1'b1;
                    m_addr[idx] = m_miss;
                    m_data[idx] = mem_word(m_miss);
                    m_busy      = 1'b0;
                end
            end else begin
                wa  = bus.imemaddr & ~32'd3;
                idx = int'((wa >> 2) % NSETS);
                h   = bus.imemREN && m_vld[idx] && (m_addr[idx] == wa);
                check("mdl_idle_ihit", {31'd0, bus.ihit}, {31'd0, h});
                check("mdl_idle_load", bus.imemload, h ? m_data[idx] : 32'd0);
                check("mdl_idle_iren", {31'd0, bus.iREN}, 32'd0);
                check("mdl_idle_iaddr", bus.iaddr, 32'd0);
                if (bus.imemREN && !h) begin
                    m_busy = 1'b1;
                    m_miss = wa;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Request `a` until ihit; waits = non-hit cycles seen before the hit.
    task automatic fetch(input logic [31:0] a, output int waits, output logic [31:0] word);
        bit done;
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        waits = 0;
        word  = '0;
        done  = 1'b0;
        while (!done) begin
            @(negedge CLK);
            if (bus.ihit) begin
                word = bus.imemload;
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 100) begin
                    check("fetch_timeout", waits, 32'd0);
                    done = 1'b1;
                end
            end
            cyc();
        end
    endtask

    initial begin
        int          w;
        logic [31:0] d;
        nRST         = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = '0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;

        @(negedge CLK);
        check("reset_iren", {31'd0, bus.iREN}, 32'd0);
        check("reset_ihit", {31'd0, bus.ihit}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1 nRST = 1'b1;

        // Cold fetch of 0x0 with three wait cycles.
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0;
        @(negedge CLK);
        check("cold_c0_ihit", {31'd0, bus.ihit}, 32'd0);
        check("cold_c0_iren", {31'd0, bus.iREN}, 32'd0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("cold_iren", {31'd0, bus.iREN}, 32'd1);
            check("cold_iaddr", bus.iaddr, 32'h0);
            check("cold_ihit", {31'd0, bus.ihit}, 32'd0);
            cyc();
        end
        @(negedge CLK);
        check("cold_hit", {31'd0, bus.ihit}, 32'd1);
        check("cold_data", bus.imemload, 32'h8C01_0004);
        cyc();
        @(negedge CLK);
        check("repeat_hit", {31'd0, bus.ihit}, 32'd1);
        check("repeat_iren", {31'd0, bus.iREN}, 32'd0);
        check("repeat_data", bus.imemload, 32'h8C01_0004);
        cyc();

        // Conflict eviction on index 1.
        fetch(32'h4, w, d);
        check("conf_fill4_data", d, 32'h1111_1111);
        check("conf_fill4_wait", w, 32'd5);
        fetch(32'h44, w, d);
        check("conf_fill44_data", d, 32'h2222_2222);
        check("conf_fill44_wait", w, 32'd5);
        bus.imemaddr = 32'h4;
        @(negedge CLK);
        check("conf_refetch_miss", {31'd0, bus.ihit}, 32'd0);
        cyc();
        @(negedge CLK);
        check("conf_refetch_iren", {31'd0, bus.iREN}, 32'd1);
        check("conf_refetch_iaddr", bus.iaddr, 32'h4);
        cyc();
        fetch(32'h4, w, d);
        check("conf_refetch_data", d, 32'h1111_1111);

        // Redirect during a miss.
        lat = 6;
        bus.imemaddr = 32'h100;
        @(negedge CLK);
        cyc();
        bus.imemaddr = 32'h200;
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            check("redir_iaddr_hold", bus.iaddr, 32'h100);
            check("redir_iren_hold", {31'd0, bus.iREN}, 32'd1);
            cyc();
        end
        @(negedge CLK);
        check("redir_new_miss", {31'd0, bus.ihit}, 32'd0);
        check("redir_idle_iren", {31'd0, bus.iREN}, 32'd0);
        cyc();
        @(negedge CLK);
        check("redir_new_iaddr", bus.iaddr, 32'h200);
        cyc();
        fetch(32'h200, w, d);
        check("redir_new_data", d, mem_word(32'h200));

        // Asynchronous reset in the middle of a miss.
        lat = 10;
        bus.imemaddr = 32'h300;
        @(negedge CLK);
        cyc();
        cyc();
        cyc();
        nRST = 1'b0;
        #1;
        check("rstmid_iren", {31'd0, bus.iREN}, 32'd0);
        check("rstmid_ihit", {31'd0, bus.ihit}, 32'd0);
        check("rstmid_iaddr", bus.iaddr, 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1 nRST = 1'b1;
        lat = 3;
        fetch(32'h4, w, d);
        check("rstmid_refetch_wait", w, 32'd5);
        check("rstmid_refetch_data", d, 32'h1111_1111);

        // Pre-fill 0x0..0x3C, then sweep one word per cycle.
        lat = 1;
        for (int i = 0; i < 16; i++) begin
            fetch(32'(i * 4), w, d);
        end
        for (int i = 0; i < 16; i++) begin
            bus.imemaddr = 32'(i * 4);
            @(negedge CLK);
            check("sweep_hit", {31'd0, bus.ihit}, 32'd1);
            check("sweep_data", bus.imemload, mem_word(32'(i * 4)));
            cyc();
        end
        bus.imemREN = 1'b0;
        @(negedge CLK);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the PC unit and the memory controller's instruction port.
- Accepts the PC's fetch address (imemaddr) and returns the instruction word with an ihit strobe. This ihit is the one the PC unit consumes to advance.
- On a miss, fetches one word from memory through the iREN/iwait handshake, fills the line, then serves the hit.
- It is the responder end of the PC's fetch interface.

Parameters:
- NSETS, 16, number of one-word lines; power of two, 2..256.
- IDXW, log2(NSETS), index width; derived, not overridden.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  datapath fetch request valid.
- imemaddr  input  32  fetch byte address from the PC unit (word_t).
- ihit  output  1  instruction valid this cycle for imemaddr.
- imemload  output  32  instruction word; 0 when ihit=0.
- iREN  output  1  read request to the memory controller.
- iaddr  output  32  word-aligned memory read address.
- iwait  input  1  memory busy; data valid on the cycle iwait=0 while iREN=1.
- iload  input  32  memory read data.

Behaviour:
- Address split:
  - [1:0] ignored; imemaddr is always word-aligned.
  - Index = [IDXW+1:2].
  - Tag = [31:IDXW+2].
- Storage: per line, a valid bit, a tag and a 32-bit data word. Storage is flops, not RAM.
- FSM states:
  - IDLE.
  - MISS.
- IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==addr tag).
  - ihit = hit, combinational, same cycle. imemload = data[idx] when hit, else 0.
  - imemREN=1 and not hit: latch imemaddr into miss_addr and go to MISS next edge. ihit=0 this cycle.
  - imemREN=0: stay in IDLE, ihit=0, iREN=0.
- MISS:
  - iREN=1; iaddr = {miss_addr[31:2],2'b00}; ihit=0.
  - iwait=1: hold in MISS, with iREN and iaddr stable.
  - iwait=0: on the next edge, write valid=1, tag and data=iload into the miss_addr index, and return to IDLE.
  - The fill is not forwarded. The hit occurs in the first IDLE cycle after the fill, so miss latency = memory latency + 1 cycle.
- imemaddr changes while in MISS (e.g. branch redirect): the fill for miss_addr still completes. The new address is looked up in IDLE afterwards and may miss again.
- imemREN dropping during MISS does not abort the fill.
- iREN and iaddr are 0 in IDLE.
- A fill into an occupied line overwrites it unconditionally. Replacement is direct-mapped with no write-back; instruction memory is read-only to this block.
- Reset (nRST=0), asynchronous and at any time including mid-MISS:
  - State goes to IDLE and all valid bits clear.
  - iREN=0, iaddr=0, ihit=0, imemload=0.
  - Tag and data contents need not reset.
  - A pending memory read is abandoned. The memory controller tolerates iREN dropping.
- Hit/miss counters are not part of this block.

Test Plan:
- Reset then cold fetch: nRST low 2 cycles, release; imemREN=1, imemaddr=0x00000000; memory returns 0x8C010004 after 3 iwait cycles → iREN=1 with iaddr=0x0 for 4 cycles, ihit=0 throughout, then ihit=1 with imemload=0x8C010004 on the following cycle.
- Repeat hit: after the above, imemaddr=0x0 again → ihit=1 same cycle, iREN=0, no memory traffic.
- Conflict eviction (NSETS=16): fill 0x00000004 (data 0x11111111), then fetch 0x00000044 (same index 1, different tag, data 0x22222222) → miss, fill; re-fetch 0x4 → miss again, iaddr=0x00000004.
- Redirect during miss: miss on 0x00000100; while iwait=1 change imemaddr to 0x00000200 → iaddr stays 0x00000100 until iwait=0. Then line 0 holds tag for 0x100, and 0x200 misses with iaddr=0x00000200.
- Reset mid-miss: assert nRST during MISS with iwait=1 → iREN=0 and ihit=0 immediately (asynchronous). After release, a fetch of the same address misses again (valid cleared).
- Back-to-back sequential hits: pre-fill 0x0..0x3C; sweep imemaddr +4 every cycle with imemREN=1 → ihit=1 every cycle, with imemload matching the filled data.
